sonar_scheduler: RTL

Bus-mastering sequencer that shares up to four `sonar` peripherals and fires them one at a time, round-robin, so their echoes never overlap. It drives each sonar's 8-bit register port: it arms the sonar, polls it until the measurement completes, then reads the range. It exposes the latest ranges and per-sonar valid/error flags to the CPU through a standard 8-bit peripheral register port.

---
 rtl/sonar_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin sequencer that arms, polls and reads up to four
// sonar peripherals over a shared register bus, exposing results to the CPU.
module sonar_scheduler #(
  parameter int          NUM_SONARS     = 4,
  parameter logic [7:0]  SONAR_BASE     = 8'h00,
  parameter logic [7:0]  HOST_ADDRESS   = 8'h00,
  parameter logic [15:0] GAP_CYCLES     = 16'd16000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic [7:0] s_address,
  output logic [7:0] s_din,
  output logic       s_w_en,
  output logic       s_r_en,
  input  logic [7:0] s_dout,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_POLL_REQ, S_POLL_CHK, S_READ_REQ, S_READ_CAP, S_GAP, S_NEXT
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_SONARS - 1);

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic        enable, sweep_req;
  logic [23:0] to_cnt;
  logic [15:0] gap_cnt;
  logic [7:0]  range_q [4];
  logic [3:0]  valid, error;
  logic [7:0]  off, ctrl_addr, rd_data;
  logic        ctrl_wr, enable_eff, timed_out, gap_done, tmo_hit, wrap_stop;
  logic        unused_din;

  assign off        = address - HOST_ADDRESS;
  assign ctrl_wr    = w_en && (off == 8'd0);
  // A CTRL write landing on the wrap cycle decides whether the sweep continues.
  assign enable_eff = ctrl_wr ? din[0] : enable;
  assign ctrl_addr  = SONAR_BASE + {5'b0, idx, 1'b0};
  assign timed_out  = (to_cnt >= TIMEOUT_CYCLES);
  assign gap_done   = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign tmo_hit    = (state == S_POLL_CHK) && s_dout[0] && timed_out;
  assign wrap_stop  = (state == S_NEXT) && (idx == LAST_IDX) && !enable_eff;
  assign state_dbg  = state;
  assign unused_din = ^din[7:2];

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE:     if (enable || sweep_req) begin
                    state_nx = S_ARM;
                    idx_nx   = 2'd0;
                  end
      S_ARM:      state_nx = S_POLL_REQ;
      S_POLL_REQ: state_nx = S_POLL_CHK;
      S_POLL_CHK: if (!s_dout[0])    state_nx = S_READ_REQ;
                  else if (timed_out) state_nx = S_GAP;
                  else               state_nx = S_POLL_REQ;
      S_READ_REQ: state_nx = S_READ_CAP;
      S_READ_CAP: state_nx = S_GAP;
      S_GAP:      if (gap_done) state_nx = S_NEXT;
      S_NEXT:     if (idx == LAST_IDX) begin
                    idx_nx   = 2'd0;
                    state_nx = enable_eff ? S_ARM : S_IDLE;
                  end else begin
                    idx_nx   = idx + 2'd1;
                    state_nx = S_ARM;
                  end
      default:    state_nx = S_IDLE;
    endcase
  end

  // Sonar bus: single-cycle strobes, never both high; read data is sampled the
  // cycle after s_r_en. Address and data are zero outside strobe cycles.
  always_comb begin
    s_w_en    = (state == S_ARM);
    s_r_en    = (state == S_POLL_REQ) || (state == S_READ_REQ);
    s_din     = (state == S_ARM) ? 8'h01 : 8'h00;
    s_address = 8'h00;
    if (state == S_ARM || state == S_POLL_REQ) s_address = ctrl_addr;
    else if (state == S_READ_REQ)              s_address = ctrl_addr + 8'd1;
  end

  always_comb begin
    rd_data = 8'h00;
    if (off == 8'd0) rd_data = {state != S_IDLE, 6'b0, enable};
    if (off == 8'd1) rd_data = {error, valid};
    for (int i = 0; i < 4; i++)
      if (i < NUM_SONARS && off == 8'(2 + i)) rd_data = range_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      to_cnt  <= 24'd0;
      gap_cnt <= 16'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == S_ARM)
        to_cnt <= 24'd0;
      else if ((state == S_POLL_REQ || state == S_POLL_CHK) && to_cnt < TIMEOUT_CYCLES)
        to_cnt <= to_cnt + 24'd1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      sweep_req <= 1'b0;
      valid     <= 4'd0;
      error     <= 4'd0;
      dout      <= 8'h00;
      for (int i = 0; i < 4; i++) range_q[i] <= 8'h00;
    end else begin
      if (ctrl_wr) enable <= din[0];
      if (ctrl_wr && din[1]) sweep_req <= 1'b1;
      else if (wrap_stop)    sweep_req <= 1'b0;
      if (r_en) dout <= rd_data;
      // Capture or timeout of the active sonar overrides a same-cycle read-clear.
      for (int i = 0; i < 4; i++) begin
        if (i < NUM_SONARS) begin
          if (idx == 2'(i) && state == S_READ_CAP) begin
            range_q[i] <= s_dout;
            valid[i]   <= 1'b1;
            error[i]   <= 1'b0;
          end else if (idx == 2'(i) && tmo_hit) begin
            range_q[i] <= 8'hFF;
            error[i]   <= 1'b1;
          end else if (r_en && off == 8'(2 + i)) begin
            valid[i] <= 1'b0;
            error[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
